// File: rtl/rs_age_multi_cdb.sv
// ALU reservation station: DEPTH renamed ops, NCDB-channel wakeup, oldest-ready issue
// chosen through an age matrix, and full flush on mispredict.
module rs_age_multi_cdb #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned NCDB   = 2,
   parameter int unsigned ROB_W  = 4,
   parameter int unsigned TYPE_W = 5,
   parameter int unsigned XLEN   = 32,
   localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ROB_W-1:0]        in_tag,
   input  logic [TYPE_W-1:0]       in_type,
   input  logic [XLEN-1:0]         in_v1,
   input  logic [XLEN-1:0]         in_v2,
   input  logic [ROB_W-1:0]        in_q1,
   input  logic [ROB_W-1:0]        in_q2,
   input  logic                    in_d1,
   input  logic                    in_d2,
   input  logic [NCDB-1:0]         cdb_valid,
   input  logic [NCDB*ROB_W-1:0]   cdb_tag,
   input  logic [NCDB*XLEN-1:0]    cdb_value,
   output logic                    issue_valid,
   input  logic                    issue_ready,
   output logic [ROB_W-1:0]        issue_tag,
   output logic [TYPE_W-1:0]       issue_type,
   output logic [XLEN-1:0]         issue_v1,
   output logic [XLEN-1:0]         issue_v2,
   output logic [CW-1:0]           count,
   output logic                    full
);

   localparam int unsigned IW = $clog2(DEPTH);

   logic [DEPTH-1:0]  valid_q, valid_d, d1_q, d1_d, d2_q, d2_d;
   logic [ROB_W-1:0]  tag_q [DEPTH];
   logic [ROB_W-1:0]  tag_d [DEPTH];
   logic [ROB_W-1:0]  q1_q [DEPTH];
   logic [ROB_W-1:0]  q1_d [DEPTH];
   logic [ROB_W-1:0]  q2_q [DEPTH];
   logic [ROB_W-1:0]  q2_d [DEPTH];
   logic [TYPE_W-1:0] type_q [DEPTH];
   logic [TYPE_W-1:0] type_d [DEPTH];
   logic [XLEN-1:0]   v1_q [DEPTH];
   logic [XLEN-1:0]   v1_d [DEPTH];
   logic [XLEN-1:0]   v2_q [DEPTH];
   logic [XLEN-1:0]   v2_d [DEPTH];
   // older_q[j][i]: entry j is older than entry i
   logic [DEPTH-1:0]  older_q [DEPTH];
   logic [DEPTH-1:0]  older_d [DEPTH];
   logic [CW-1:0]     count_q, count_d;

   logic [DEPTH-1:0]  ready, blocked, sel;
   logic [IW-1:0]     issue_idx, free_idx;
   logic              enq_fire, iss_fire;
   logic [XLEN-1:0]   byp_v1, byp_v2;
   logic              byp_d1, byp_d2;

   always_comb begin
      ready   = valid_q & ~d1_q & ~d2_q;
      blocked = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         for (int j = 0; j < int'(DEPTH); j++) begin
            if (ready[j] && older_q[j][i]) blocked[i] = 1'b1;
         end
      end
      sel       = ready & ~blocked;
      issue_idx = '0;
      free_idx  = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (sel[i]) issue_idx = IW'(i);
         if (!valid_q[i]) free_idx = IW'(i);
      end
   end

   assign count       = count_q;
   assign full        = (count_q == CW'(DEPTH));
   assign in_ready    = ~full;
   assign issue_valid = |ready;
   assign issue_tag   = tag_q[issue_idx];
   assign issue_type  = type_q[issue_idx];
   assign issue_v1    = v1_q[issue_idx];
   assign issue_v2    = v2_q[issue_idx];
   assign enq_fire    = rdy & in_valid & in_ready;
   assign iss_fire    = rdy & issue_valid & issue_ready;

   // Same-cycle bypass; descending scan so the lowest matching channel wins.
   always_comb begin
      byp_v1 = in_v1;
      byp_d1 = in_d1;
      byp_v2 = in_v2;
      byp_d2 = in_d2;
      for (int c = int'(NCDB) - 1; c >= 0; c--) begin
         if (in_d1 && cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == in_q1) begin
            byp_v1 = cdb_value[c*XLEN +: XLEN];
            byp_d1 = 1'b0;
         end
         if (in_d2 && cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == in_q2) begin
            byp_v2 = cdb_value[c*XLEN +: XLEN];
            byp_d2 = 1'b0;
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      tag_d   = tag_q;
      type_d  = type_q;
      q1_d    = q1_q;
      q2_d    = q2_q;
      v1_d    = v1_q;
      v2_d    = v2_q;
      older_d = older_q;
      count_d = count_q;
      if (flush) begin
         valid_d = '0;
         count_d = '0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            for (int c = int'(NCDB) - 1; c >= 0; c--) begin
               if (valid_q[i] && d1_q[i] && cdb_valid[c] &&
                   cdb_tag[c*ROB_W +: ROB_W] == q1_q[i]) begin
                  v1_d[i] = cdb_value[c*XLEN +: XLEN];
                  d1_d[i] = 1'b0;
               end
               if (valid_q[i] && d2_q[i] && cdb_valid[c] &&
                   cdb_tag[c*ROB_W +: ROB_W] == q2_q[i]) begin
                  v2_d[i] = cdb_value[c*XLEN +: XLEN];
                  d2_d[i] = 1'b0;
               end
            end
         end
         if (iss_fire) valid_d[issue_idx] = 1'b0;
         // free_idx comes from valid_q, so a slot freed by this issue is never reused here
         if (enq_fire) begin
            valid_d[free_idx] = 1'b1;
            tag_d[free_idx]   = in_tag;
            type_d[free_idx]  = in_type;
            q1_d[free_idx]    = in_q1;
            q2_d[free_idx]    = in_q2;
            v1_d[free_idx]    = byp_v1;
            v2_d[free_idx]    = byp_v2;
            d1_d[free_idx]    = byp_d1;
            d2_d[free_idx]    = byp_d2;
            for (int j = 0; j < int'(DEPTH); j++) older_d[j][free_idx] = valid_q[j];
            older_d[free_idx] = '0;
         end
         count_d = count_q + CW'(enq_fire) - CW'(iss_fire);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         count_q <= '0;
         for (int j = 0; j < int'(DEPTH); j++) older_q[j] <= '0;
      end else if (rdy) begin
         valid_q <= valid_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         count_q <= count_d;
         older_q <= older_d;
      end
   end

   // Payload is only meaningful under valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (rdy) begin
         tag_q  <= tag_d;
         type_q <= type_d;
         q1_q   <= q1_d;
         q2_q   <= q2_d;
         v1_q   <= v1_d;
         v2_q   <= v2_d;
      end
   end

endmodule

// File: tb/tb_rs_age_multi_cdb.sv
// Self-checking bench for rs_age_multi_cdb: directed scenarios with an in-order scoreboard
// of expected issues, checked whenever the ALU handshake fires.
module tb_rs_age_multi_cdb;

   localparam int DEPTH = 8;
   localparam int NCDB  = 2;
   localparam int ROB_W = 4;
   localparam int TW    = 5;
   localparam int XLEN  = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct {
      logic [ROB_W-1:0] tag;
      logic [TW-1:0]    typ;
      logic [XLEN-1:0]  v1;
      logic [XLEN-1:0]  v2;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst, rdy, flush, in_valid, in_ready;
   logic [ROB_W-1:0]      in_tag, in_q1, in_q2;
   logic [TW-1:0]         in_type;
   logic [XLEN-1:0]       in_v1, in_v2;
   logic                  in_d1, in_d2;
   logic [NCDB-1:0]       cdb_valid;
   logic [NCDB*ROB_W-1:0] cdb_tag;
   logic [NCDB*XLEN-1:0]  cdb_value;
   logic                  issue_valid, issue_ready;
   logic [ROB_W-1:0]      issue_tag;
   logic [TW-1:0]         issue_type;
   logic [XLEN-1:0]       issue_v1, issue_v2;
   logic [CW-1:0]         count;
   logic                  full;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   rs_age_multi_cdb #(
      .DEPTH(DEPTH), .NCDB(NCDB), .ROB_W(ROB_W), .TYPE_W(TW), .XLEN(XLEN)
   ) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_type(in_type),
      .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2),
      .in_d1(in_d1), .in_d2(in_d2),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
      .issue_type(issue_type), .issue_v1(issue_v1), .issue_v2(issue_v2),
      .count(count), .full(full)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      in_tag    = '0;
      in_type   = '0;
      in_v1     = '0;
      in_v2     = '0;
      in_q1     = '0;
      in_q2     = '0;
      in_d1     = 1'b0;
      in_d2     = 1'b0;
      cdb_valid = '0;
      cdb_tag   = '0;
      cdb_value = '0;
   endtask

   task automatic set_enq(input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] v1,
                          input logic [XLEN-1:0] v2, input logic [ROB_W-1:0] q1,
                          input logic [ROB_W-1:0] q2, input logic d1, input logic d2);
      in_valid = 1'b1;
      in_tag   = tag;
      in_type  = {1'b1, tag};
      in_v1    = v1;
      in_v2    = v2;
      in_q1    = q1;
      in_q2    = q2;
      in_d1    = d1;
      in_d2    = d2;
   endtask

   task automatic set_cdb(input int ch, input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] val);
      cdb_valid[ch]              = 1'b1;
      cdb_tag[ch*ROB_W +: ROB_W] = tag;
      cdb_value[ch*XLEN +: XLEN] = val;
   endtask

   task automatic push_exp(input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] v1,
                           input logic [XLEN-1:0] v2);
      exp_t e;
      e.tag = tag;
      e.typ = {1'b1, tag};
      e.v1  = v1;
      e.v2  = v2;
      exp_q.push_back(e);
   endtask

   // Scoreboard: every accepted issue must match the next expected op, in order.
   task automatic run_monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && rdy && !flush && issue_valid && issue_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL issue_unexpected got tag=%0d want no issue", issue_tag);
            end else begin
               e = exp_q.pop_front();
               if ({issue_tag, issue_type, issue_v1, issue_v2} !== {e.tag, e.typ, e.v1, e.v2}) begin
                  failures++;
                  $display("FAIL issue_payload got tag=%0d type=%0h v1=%0h v2=%0h want tag=%0d type=%0h v1=%0h v2=%0h",
                           issue_tag, issue_type, issue_v1, issue_v2, e.tag, e.typ, e.v1, e.v2);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) cyc();
      checks++;
      if (count !== 0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
      checks++;
      if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b want=0", full); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
      checks++;
      if (issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid got=%0b want=0", issue_valid); end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_basic();
      issue_ready = 1'b1;
      set_enq(4'd3, 32'd5, 32'd7, 4'd0, 4'd0, 1'b0, 1'b0);
      push_exp(4'd3, 32'd5, 32'd7);
      cyc();
      idle();
      checks++;
      if (count !== 1) begin failures++; $display("FAIL basic_count1 got=%0d want=1", count); end
      checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 4'd3) begin
         failures++;
         $display("FAIL basic_present got valid=%0b tag=%0d want valid=1 tag=3", issue_valid, issue_tag);
      end
      cyc();
      checks++;
      if (count !== 0) begin failures++; $display("FAIL basic_count0 got=%0d want=0", count); end
   endtask

   task automatic test_wakeup();
      issue_ready = 1'b1;
      set_enq(4'd2, 32'h55, 32'h11, 4'd6, 4'd0, 1'b1, 1'b0);
      set_cdb(0, 4'd5, 32'hBB);
      set_cdb(1, 4'd6, 32'hAA);
      push_exp(4'd2, 32'hAA, 32'h11);
      cyc();
      idle();
      checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 4'd2) begin
         failures++;
         $display("FAIL bypass_present got valid=%0b tag=%0d want valid=1 tag=2", issue_valid, issue_tag);
      end
      cyc();
      // Both channels match: channel 0 must win.
      set_enq(4'd7, 32'h70, 32'h0, 4'd0, 4'd6, 1'b0, 1'b1);
      set_cdb(0, 4'd6, 32'h33);
      set_cdb(1, 4'd6, 32'h44);
      push_exp(4'd7, 32'h70, 32'h33);
      cyc();
      idle();
      cyc();
      checks++;
      if (count !== 0) begin failures++; $display("FAIL bypass_prio_count got=%0d want=0", count); end
      // Snoop wakeup of both operands from different channels in one cycle.
      issue_ready = 1'b0;
      set_enq(4'd4, 32'h1, 32'h2, 4'd9, 4'd12, 1'b1, 1'b1);
      cyc();
      idle();
      checks++;
      if (issue_valid !== 1'b0) begin failures++; $display("FAIL wake_blocked got=%0b want=0", issue_valid); end
      set_cdb(0, 4'd9, 32'h99);
      set_cdb(1, 4'd12, 32'h12);
      cyc();
      idle();
      checks++;
      if (issue_valid !== 1'b1) begin failures++; $display("FAIL wake_ready got=%0b want=1", issue_valid); end
      push_exp(4'd4, 32'h99, 32'h12);
      issue_ready = 1'b1;
      cyc();
      checks++;
      if (count !== 0) begin failures++; $display("FAIL wake_count got=%0d want=0", count); end
   endtask

   task automatic test_age();
      issue_ready = 1'b0;
      set_enq(4'd1, 32'h0, 32'h21, 4'd8, 4'd0, 1'b1, 1'b0);
      cyc();
      set_enq(4'd2, 32'h12, 32'h22, 4'd0, 4'd0, 1'b0, 1'b0);
      cyc();
      set_enq(4'd3, 32'h13, 32'h23, 4'd0, 4'd0, 1'b0, 1'b0);
      cyc();
      idle();
      checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 4'd2) begin
         failures++;
         $display("FAIL age_pick2 got valid=%0b tag=%0d want valid=1 tag=2", issue_valid, issue_tag);
      end
      set_cdb(0, 4'd8, 32'h81);
      cyc();
      idle();
      checks++;
      if (issue_tag !== 4'd1) begin failures++; $display("FAIL age_pick1 got=%0d want=1", issue_tag); end
      push_exp(4'd1, 32'h81, 32'h21);
      push_exp(4'd2, 32'h12, 32'h22);
      push_exp(4'd3, 32'h13, 32'h23);
      issue_ready = 1'b1;
      repeat (3) cyc();
      checks++;
      if (count !== 0) begin failures++; $display("FAIL age_count got=%0d want=0", count); end
   endtask

   task automatic test_full();
      issue_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         set_enq(4'(i), 32'h0, 32'h200 + i, 4'(8 + i), 4'd0, 1'b1, 1'b0);
         cyc();
      end
      idle();
      checks++;
      if (full !== 1'b1 || in_ready !== 1'b0 || count !== 8) begin
         failures++;
         $display("FAIL full_flags got full=%0b in_ready=%0b count=%0d want 1 0 8", full, in_ready, count);
      end
      set_enq(4'd9, 32'h9, 32'h9, 4'd0, 4'd0, 1'b0, 1'b0);
      cyc();
      idle();
      checks++;
      if (count !== 8) begin failures++; $display("FAIL full_ninth got count=%0d want=8", count); end
      set_cdb(0, 4'd11, 32'h3B);
      cyc();
      idle();
      checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 4'd3) begin
         failures++;
         $display("FAIL full_wake got valid=%0b tag=%0d want valid=1 tag=3", issue_valid, issue_tag);
      end
      push_exp(4'd3, 32'h3B, 32'h203);
      issue_ready = 1'b1;
      set_enq(4'd12, 32'hC1, 32'hC2, 4'd0, 4'd0, 1'b0, 1'b0);
      cyc();
      issue_ready = 1'b0;
      checks++;
      if (count !== 7 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL full_same_cycle got count=%0d in_ready=%0b want 7 1", count, in_ready);
      end
      cyc();
      idle();
      checks++;
      if (count !== 8 || issue_tag !== 4'd12) begin
         failures++;
         $display("FAIL full_refill got count=%0d tag=%0d want 8 12", count, issue_tag);
      end
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      checks++;
      if (count !== 0) begin failures++; $display("FAIL full_drain got=%0d want=0", count); end
   endtask

   task automatic test_flush();
      issue_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         set_enq(4'(i), 32'(i), 32'(16 * i), 4'd0, 4'd0, 1'b0, 1'b0);
         cyc();
      end
      idle();
      checks++;
      if (count !== 5 || issue_tag !== 4'd1) begin
         failures++;
         $display("FAIL flush_setup got count=%0d tag=%0d want 5 1", count, issue_tag);
      end
      flush       = 1'b1;
      issue_ready = 1'b1;
      set_enq(4'd6, 32'h6, 32'h6, 4'd0, 4'd0, 1'b0, 1'b0);
      cyc();
      flush = 1'b0;
      idle();
      checks++;
      if (count !== 0 || issue_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_clear got count=%0d valid=%0b want 0 0", count, issue_valid);
      end
      cyc();
      checks++;
      if (count !== 0 || issue_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_stay got count=%0d valid=%0b want 0 0", count, issue_valid);
      end
      issue_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         set_enq(4'(i), 32'(i), 32'(16 * i), 4'd0, 4'd0, 1'b0, 1'b0);
         cyc();
      end
      idle();
      rdy         = 1'b0;
      flush       = 1'b1;
      issue_ready = 1'b1;
      set_enq(4'd7, 32'h7, 32'h7, 4'd0, 4'd0, 1'b0, 1'b0);
      repeat (2) cyc();
      checks++;
      if (count !== 3 || issue_valid !== 1'b1 || issue_tag !== 4'd1 || issue_v1 !== 32'd1) begin
         failures++;
         $display("FAIL hold_state got count=%0d valid=%0b tag=%0d v1=%0h want 3 1 1 1",
                  count, issue_valid, issue_tag, issue_v1);
      end
      rdy   = 1'b1;
      flush = 1'b0;
      idle();
      for (int i = 1; i <= 3; i++) push_exp(4'(i), 32'(i), 32'(16 * i));
      repeat (3) cyc();
      issue_ready = 1'b0;
      checks++;
      if (count !== 0) begin failures++; $display("FAIL hold_drain got=%0d want=0", count); end
   endtask

   initial begin
      rst         = 1'b1;
      rdy         = 1'b1;
      flush       = 1'b0;
      issue_ready = 1'b0;
      idle();
      fork
         run_monitor();
      join_none
      test_reset();
      test_basic();
      test_wakeup();
      test_age();
      test_full();
      test_flush();
      cyc();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
